hazard_detect_unit: RTL and testbench
=====================================

HAZARD_DETECT_UNIT -- requirements
Module: hazard_detect_unit

Interface
REQ-001 SHALL have parameter J_PENALTY, default 1, number of stall_j cycles per jump/taken branch (legal 1..7).
REQ-002 SHALL have parameter STAT_W, default 16, width of each statistics counter.
REQ-003 SHALL have port clock  in  1  single rising-edge clock.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port id_valid  in  1  ID holds a real instruction.
REQ-006 SHALL have ports id_rs1, id_rs2  in  5 each  ID source register numbers.
REQ-007 SHALL have ports id_use_rs1, id_use_rs2  in  1 each  ID instruction reads that source.
REQ-008 SHALL have port id_rd  in  5  ID destination register.
REQ-009 SHALL have port id_is_load  in  1  ID instruction is LB/LH/LW/LBU/LHU.
REQ-010 SHALL have port id_is_jump  in  1  ID instruction is JAL/JALR.
REQ-011 SHALL have port ex_branch_taken  in  1  branch in EX resolved taken.
REQ-012 SHALL have port stall_lw  out  1  load-use stall request to stall_handle_unit.
REQ-013 SHALL have port stall_j  out  1  control-flow stall request to stall_handle_unit.
REQ-014 SHALL have ports lw_stall_cnt, j_stall_cnt  out  STAT_W each  present only with HAZARD_STATS_EN.

Function
REQ-015 SHALL keep an EX shadow register (ex_rd, ex_is_load) mirroring the instruction in EX.
REQ-016 SHALL, each rising edge, load the shadow with id_rd/id_is_load when id_valid and no stall is output that cycle; otherwise load a bubble (ex_rd=0, ex_is_load=0).
REQ-017 SHALL assert stall_lw combinationally when id_valid, ex_is_load, ex_rd!=0 and ((id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd)).
REQ-018 SHALL give a load-use stall exactly one cycle, the bubble of REQ-016 clearing the condition.
REQ-019 SHALL implement FSM states IDLE, J_FLUSH with a 3-bit down-counter flush_cnt.
REQ-020 SHALL, in IDLE, on ex_branch_taken, or on id_valid and id_is_jump with no stall_lw, assert stall_j that cycle and, if J_PENALTY>1, go to J_FLUSH with flush_cnt=J_PENALTY-2.
REQ-021 SHALL, in J_FLUSH, assert stall_j, ignore id_valid (treat as bubble), decrement flush_cnt, return to IDLE after the cycle flush_cnt==0.
REQ-022 SHALL give ex_branch_taken priority over load-use: stall_lw forced 0 when ex_branch_taken.
REQ-023 SHALL restart J_FLUSH at J_PENALTY-2 on ex_branch_taken during J_FLUSH.
REQ-024 SHALL never assert stall_lw and stall_j in the same cycle.
REQ-025 SHALL treat rd==x0 as never producing a hazard.

Reset
REQ-026 SHALL, while reset_n=0, force state=IDLE, flush_cnt=0, ex_rd=0, ex_is_load=0, stall_lw=0, stall_j=0, statistics counters=0.
REQ-027 SHALL abandon any in-progress flush when reset asserts mid-operation; first post-reset cycle is IDLE.

Configuration
REQ-028 SHALL, with HAZARD_STATS_EN defined, increment lw_stall_cnt per stall_lw cycle and j_stall_cnt per stall_j cycle, saturating at all-ones.
REQ-029 SHALL, without HAZARD_STATS_EN, omit both counter ports and their logic; stall behaviour identical.

Structure
REQ-030 SHALL take the state enum, REG_W=5 and X0 constant from shared package rv32_hazard_pkg.
REQ-031 SHALL place the EX shadow register and the REQ-017 compare in sub-module hazard_ex_shadow; FSM and counters stay in the top.

Verification
REQ-032 LW x5 then ADD x6,x5,x1 (rs1=5) -> stall_lw=1 one cycle, stall_j=0, then ADD proceeds with stall_lw=0.
REQ-033 LW x0 then ADD x6,x0,x1 -> stall_lw never asserted.
REQ-034 JAL with J_PENALTY=3 -> stall_j=1 for exactly 3 consecutive cycles, IDLE afterwards.
REQ-035 ex_branch_taken=1 in the same cycle as a load-use match -> stall_j=1, stall_lw=0.
REQ-036 reset_n pulled low in second J_FLUSH cycle -> stall_j=0 immediately, state IDLE after release.
REQ-037 HAZARD_STATS_EN, STAT_W=2, five load-use stalls -> lw_stall_cnt saturates at 3.

Source files
------------

// File: rtl/rv32_hazard_pkg.sv
// Shared types and constants for the RV32 hazard detection slice.
// Holds the jump-flush FSM state encoding and register-index constants.
package rv32_hazard_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] X0 = '0;

  typedef enum logic {
    IDLE    = 1'b0,
    J_FLUSH = 1'b1
  } hd_state_e;
endpackage

// File: rtl/hazard_ex_shadow.sv
// EX-stage shadow of the destination register and load flag.
// Flags a load-use match between the ID sources and the load in EX.
module hazard_ex_shadow
  import rv32_hazard_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_is_load,
  input  logic             advance,
  output logic             lu_hit
);

  logic [REG_W-1:0] ex_rd;
  logic             ex_is_load;
  logic             rs1_hit;
  logic             rs2_hit;

  // Anything not advancing into EX becomes a bubble.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_rd      <= X0;
      ex_is_load <= 1'b0;
    end else if (advance) begin
      ex_rd      <= id_rd;
      ex_is_load <= id_is_load;
    end else begin
      ex_rd      <= X0;
      ex_is_load <= 1'b0;
    end
  end

  always_comb begin
    rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    lu_hit  = id_valid && ex_is_load && (ex_rd != X0)
              && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/hazard_detect_unit.sv
// Load-use and control-flow stall generation for the RV32 pipeline.
// Define HAZARD_STATS_EN to add saturating stall statistics counters.
module hazard_detect_unit
  import rv32_hazard_pkg::*;
#(
  parameter int J_PENALTY = 1,
  parameter int STAT_W    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_is_load,
  input  logic             id_is_jump,
  input  logic             ex_branch_taken,
  output logic             stall_lw,
  output logic             stall_j
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] lw_stall_cnt,
  output logic [STAT_W-1:0] j_stall_cnt
`endif
);

  if (J_PENALTY < 1 || J_PENALTY > 7 || STAT_W < 1) begin : g_bad_param
    $error("hazard_detect_unit: illegal J_PENALTY or STAT_W");
  end

  localparam logic [2:0] RELOAD =
    3'((J_PENALTY > 1) ? (J_PENALTY - 2) : 0);

  hd_state_e  state;
  hd_state_e  state_n;
  logic [2:0] flush_cnt;
  logic [2:0] flush_cnt_n;
  logic       id_live;
  logic       lu_hit;
  logic       take_j;
  logic       advance;

  // ID is treated as a bubble while the flush is running.
  assign id_live = id_valid && (state == IDLE);
  assign advance = id_live && !stall_lw && !stall_j;

  hazard_ex_shadow u_shadow (
    .clock      (clock),
    .reset_n    (reset_n),
    .id_valid   (id_live),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_rd      (id_rd),
    .id_is_load (id_is_load),
    .advance    (advance),
    .lu_hit     (lu_hit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      flush_cnt <= 3'd0;
    end else begin
      state     <= state_n;
      flush_cnt <= flush_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    flush_cnt_n = flush_cnt;
    unique case (state)
      IDLE: begin
        if (take_j && (J_PENALTY > 1)) begin
          state_n     = J_FLUSH;
          flush_cnt_n = RELOAD;
        end
      end
      J_FLUSH: begin
        if (ex_branch_taken) begin
          flush_cnt_n = RELOAD;
        end else if (flush_cnt == 3'd0) begin
          state_n = IDLE;
        end else begin
          flush_cnt_n = flush_cnt - 3'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Taken branch outranks load-use; a jump waits behind a load-use stall.
  always_comb begin
    stall_lw = reset_n && lu_hit && !ex_branch_taken;
    take_j   = ex_branch_taken
               || (id_live && id_is_jump && !stall_lw);
    stall_j  = reset_n && ((state == J_FLUSH) || take_j);
  end

`ifdef HAZARD_STATS_EN
  localparam logic [STAT_W-1:0] CNT_ONE = STAT_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lw_stall_cnt <= '0;
      j_stall_cnt  <= '0;
    end else begin
      if (stall_lw && (lw_stall_cnt != '1))
        lw_stall_cnt <= lw_stall_cnt + CNT_ONE;
      if (stall_j && (j_stall_cnt != '1))
        j_stall_cnt <= j_stall_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Scoreboard bench for hazard_detect_unit with J_PENALTY=3.
// Build with HAZARD_STATS_EN to also exercise the 2-bit counters.
module tb_hazard_detect_unit;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       id_use_rs1 = 1'b0;
  logic       id_use_rs2 = 1'b0;
  logic [4:0] id_rd = '0;
  logic       id_is_load = 1'b0;
  logic       id_is_jump = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       stall_lw;
  logic       stall_j;
`ifdef HAZARD_STATS_EN
  logic [1:0] lw_stall_cnt;
  logic [1:0] j_stall_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  always #5 clock = ~clock;

  hazard_detect_unit #(
    .J_PENALTY(3)
`ifdef HAZARD_STATS_EN
    , .STAT_W(2)
`endif
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .id_is_load      (id_is_load),
    .id_is_jump      (id_is_jump),
    .ex_branch_taken (ex_branch_taken),
    .stall_lw        (stall_lw),
    .stall_j         (stall_j)
`ifdef HAZARD_STATS_EN
    ,
    .lw_stall_cnt    (lw_stall_cnt),
    .j_stall_cnt     (j_stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input string tag);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_lw"}, 32'(stall_lw), 32'(e[1]));
      check({tag, "_j"}, 32'(stall_j), 32'(e[0]));
    end
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd,
                        input logic ld, input logic jp, input logic bt);
    id_valid        = v;
    id_rs1          = rs1;
    id_rs2          = rs2;
    id_use_rs1      = u1;
    id_use_rs2      = u2;
    id_rd           = rd;
    id_is_load      = ld;
    id_is_jump      = jp;
    ex_branch_taken = bt;
  endtask

  task automatic step(input string tag, input logic v,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2,
                      input logic [4:0] rd, input logic ld,
                      input logic jp, input logic bt,
                      input logic elw, input logic ej);
    set_in(v, rs1, rs2, u1, u2, rd, ld, jp, bt);
    exp_q.push_back({elw, ej});
    @(negedge clock);
    sb_pop(tag);
    @(posedge clock);
    #1;
  endtask

  task automatic nop(input string tag, input logic ej);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ej);
  endtask

  task automatic lu_pair(input string tag);
    step({tag, "_ld"}, 1, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0, 0);
    step({tag, "_use"}, 1, 5'd5, 5'd1, 1, 1, 5'd6, 0, 0, 0, 1, 0);
  endtask

  initial begin
    // reset holds outputs low even with a taken branch present
    step("rst", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    step("lw_x5", 1, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0, 0);
    step("add_rs1", 1, 5'd5, 5'd1, 1, 1, 5'd6, 0, 0, 0, 1, 0);
    step("add_go", 1, 5'd5, 5'd1, 1, 1, 5'd6, 0, 0, 0, 0, 0);

    step("lw_x7", 1, 0, 0, 0, 0, 5'd7, 1, 0, 0, 0, 0);
    step("use_rs2", 1, 5'd2, 5'd7, 1, 1, 5'd8, 0, 0, 0, 1, 0);
    step("rs2_go", 1, 5'd2, 5'd7, 1, 1, 5'd8, 0, 0, 0, 0, 0);

    step("lw_x8", 1, 0, 0, 0, 0, 5'd8, 1, 0, 0, 0, 0);
    step("no_use", 1, 5'd8, 5'd8, 0, 0, 5'd9, 0, 0, 0, 0, 0);

    step("lw_x0", 1, 0, 0, 0, 0, 5'd0, 1, 0, 0, 0, 0);
    step("add_x0", 1, 5'd0, 5'd1, 1, 1, 5'd6, 0, 0, 0, 0, 0);

    step("alu_x9", 1, 0, 0, 0, 0, 5'd9, 0, 0, 0, 0, 0);
    step("use_alu", 1, 5'd9, 5'd9, 1, 1, 5'd3, 0, 0, 0, 0, 0);

    step("lw_x10", 1, 0, 0, 0, 0, 5'd10, 1, 0, 0, 0, 0);
    step("inval", 0, 5'd10, 5'd10, 1, 1, 5'd3, 0, 0, 0, 0, 0);

    step("jal", 1, 0, 0, 0, 0, 5'd1, 0, 1, 0, 0, 1);
    nop("jal_f1", 1);
    step("jal_f2_lw", 1, 0, 0, 0, 0, 5'd11, 1, 0, 0, 0, 1);
    step("jal_idle", 1, 5'd11, 5'd1, 1, 1, 5'd4, 0, 0, 0, 0, 0);

    step("lw_x12", 1, 0, 0, 0, 0, 5'd12, 1, 0, 0, 0, 0);
    step("jalr_lu", 1, 5'd12, 5'd0, 1, 0, 5'd1, 0, 1, 0, 1, 0);
    step("jalr_go", 1, 5'd12, 5'd0, 1, 0, 5'd1, 0, 1, 0, 0, 1);
    nop("jalr_f1", 1);
    nop("jalr_f2", 1);
    nop("jalr_idle", 0);

    step("lw_x13", 1, 0, 0, 0, 0, 5'd13, 1, 0, 0, 0, 0);
    step("br_vs_lu", 1, 5'd13, 5'd1, 1, 1, 5'd6, 0, 0, 1, 0, 1);
    nop("br_f1", 1);
    nop("br_f2", 1);
    nop("br_idle", 0);

    step("br_a", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step("br_restart", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    nop("rs_f1", 1);
    nop("rs_f2", 1);
    nop("rs_idle", 0);

    step("jal_r", 1, 0, 0, 0, 0, 5'd1, 0, 1, 0, 0, 1);
    nop("jal_r_f1", 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    exp_q.push_back(2'b00);
    #1;
    sb_pop("rst_mid");
`ifdef HAZARD_STATS_EN
    check("rst_lw_cnt", 32'(lw_stall_cnt), 32'd0);
    check("rst_j_cnt", 32'(j_stall_cnt), 32'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    nop("post_rst", 0);
    step("jal_p", 1, 0, 0, 0, 0, 5'd1, 0, 1, 0, 0, 1);
    nop("jal_p_f1", 1);
    nop("jal_p_f2", 1);
    nop("jal_p_idle", 0);

`ifdef HAZARD_STATS_EN
    check("j_cnt3", 32'(j_stall_cnt), 32'd3);
    check("lw_cnt0", 32'(lw_stall_cnt), 32'd0);
`endif
    lu_pair("s1");
    lu_pair("s2");
`ifdef HAZARD_STATS_EN
    check("lw_cnt2", 32'(lw_stall_cnt), 32'd2);
`endif
    lu_pair("s3");
    lu_pair("s4");
    lu_pair("s5");
    nop("s_end", 0);
`ifdef HAZARD_STATS_EN
    check("lw_cnt_sat", 32'(lw_stall_cnt), 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
